hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage stall/forward control from a shifting (dst, Tnew) scoreboard
// Also stalls HI/LO consumers while the multiply/divide unit counts down its latency.
module hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4,
  localparam int FW     = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic          d_we,
  input  logic [4:0]    d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_start,
  input  logic          d_md_div,
  input  logic          d_hilo_use,
  output logic          stall,
  output logic [FW-1:0] fwd_rs,
  output logic [FW-1:0] fwd_rt,
  output logic          md_busy
);

  localparam logic [TW-1:0] TUSE_NONE = '1;

  // index 0 is the E stage entry, index STAGES-1 the oldest
  logic [STAGES-1:0]         vld_q, vld_d;
  logic [STAGES-1:0][4:0]    dst_q, dst_d;
  logic [STAGES-1:0][TW-1:0] tnew_q, tnew_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic          rs_hit, rt_hit;
  logic [FW-1:0] rs_idx, rt_idx;
  logic [TW-1:0] rs_tnew, rt_tnew;
  logic          data_stall;

  // Scan oldest to youngest so the youngest matching writer ends up governing.
  always_comb begin
    rs_hit  = 1'b0;
    rs_idx  = '0;
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_idx  = '0;
    rt_tnew = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (vld_q[i] && dst_q[i] != 5'd0 && dst_q[i] == d_rs && d_rs_tuse != TUSE_NONE) begin
        rs_hit  = 1'b1;
        rs_idx  = FW'(i + 1);
        rs_tnew = tnew_q[i];
      end
      if (vld_q[i] && dst_q[i] != 5'd0 && dst_q[i] == d_rt && d_rt_tuse != TUSE_NONE) begin
        rt_hit  = 1'b1;
        rt_idx  = FW'(i + 1);
        rt_tnew = tnew_q[i];
      end
    end
  end

  always_comb begin
    data_stall = (rs_hit && rs_tnew > d_rs_tuse) || (rt_hit && rt_tnew > d_rt_tuse);
    md_busy    = (cnt_q != '0);
    stall      = d_valid & (data_stall | (d_hilo_use & md_busy));
    fwd_rs     = (rs_hit && rs_tnew == '0) ? rs_idx : '0;
    fwd_rt     = (rt_hit && rt_tnew == '0) ? rt_idx : '0;
  end

  always_comb begin
    vld_d     = '0;
    dst_d     = '0;
    tnew_d    = '0;
    vld_d[0]  = d_valid & d_we & ~stall;
    dst_d[0]  = d_dst;
    tnew_d[0] = d_tnew;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      dst_d[i]  = dst_q[i-1];
      tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (d_valid & d_md_start & ~stall) begin
      cnt_d = d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      dst_q  <= '0;
      tnew_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      dst_q  <= dst_d;
      tnew_q <= tnew_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
